framebuffer_responder: RTL and testbench



---
 rtl/fs_pkg.sv | 25 ++
 rtl/fb_write_fifo.sv | 54 +++++
 rtl/framebuffer_responder.sv | 132 +++++++++++++
 tb/tb_framebuffer_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fs_pkg.sv
// Shared types and constants for the falling-sand framebuffer.
// Pixel, address and write-buffer entry definitions.
package fs_pkg;

   localparam int ADDR_W = 23;
   localparam int PIX_W  = 8;

   typedef logic [PIX_W-1:0]  pix_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      CLEAR
   } fb_state_t;

   typedef struct packed {
      addr_t addr;
      pix_t  data;
   } fb_wr_t;

   localparam pix_t CLEAR_VALUE_DEF = 8'h00;
   localparam pix_t OOR_VALUE_DEF   = 8'h00;

endpackage

// File: rtl/fb_write_fifo.sv
// Small synchronous write buffer of {address, pixel} entries.
// Wrap-bit pointers give full/empty without a counter.
module fb_write_fifo
   import fs_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [PIX_W-1:0]  push_data,
   input  logic              pop,
   output logic [ADDR_W-1:0] pop_addr,
   output logic [PIX_W-1:0]  pop_data,
   output logic              full,
   output logic              empty
);

   localparam int PW = $clog2(FIFO_DEPTH) + 1;

   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic          do_push;
   logic          do_pop;
   fb_wr_t        buf_q [FIFO_DEPTH];

   assign empty = (wp == rp);
   assign full  = (wp[PW-1] != rp[PW-1]) &&
                  (wp[PW-2:0] == rp[PW-2:0]);

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign pop_addr = buf_q[rp[PW-2:0]].addr;
   assign pop_data = buf_q[rp[PW-2:0]].data;

   always_ff @(posedge clk) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         buf_q[wp[PW-2:0]] <= '{addr: push_addr, data: push_data};
      end
   end

endmodule

// File: rtl/framebuffer_responder.sv
// Pixel RAM owner: fixed-latency render reads, buffered simulation
// writes and a whole-buffer clear sweep sharing one RAM port.
module framebuffer_responder
   import fs_pkg::*;
#(
   parameter int   DEPTH       = 76800,
   parameter int   FIFO_DEPTH  = 4,
   parameter pix_t CLEAR_VALUE = CLEAR_VALUE_DEF,
   parameter pix_t OOR_VALUE   = OOR_VALUE_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   output logic [PIX_W-1:0]  readdata,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_address,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic              clear,
   output logic              busy
);

   localparam int            AW    = $clog2(DEPTH);
   localparam addr_t         LIMIT = addr_t'(DEPTH);
   localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

   fb_state_t     state;
   fb_state_t     state_nxt;
   logic [AW-1:0] cnt;
   logic [AW-1:0] cnt_nxt;

   addr_t         rd_addr_q;
   logic          rd_v_q;

   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   addr_t         f_addr;
   pix_t          f_data;

   logic          slot;
   logic          ram_we;
   logic [AW-1:0] ram_wa;
   pix_t          ram_wd;

   pix_t          mem [DEPTH];

   assign busy     = (state != IDLE);
   assign wr_ready = !fifo_full && (state == IDLE) && !reset;
   assign push     = wr_valid && wr_ready;

   // The registered read owns the RAM; everything else waits for a gap.
   assign slot = !rd_v_q;
   assign pop  = slot && !fifo_empty && (state != CLEAR);

   fb_write_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_addr (wr_address),
      .push_data (wr_data),
      .pop       (pop),
      .pop_addr  (f_addr),
      .pop_data  (f_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ram_we    = 1'b0;
      ram_wa    = f_addr[AW-1:0];
      ram_wd    = f_data;

      if (pop && (f_addr < LIMIT)) ram_we = 1'b1;

      unique case (state)
         IDLE: begin
            if (clear) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (fifo_empty) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            if (slot) begin
               ram_we = 1'b1;
               ram_wa = cnt;
               ram_wd = CLEAR_VALUE;
               if (cnt == LAST) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rd_v_q    <= 1'b0;
         rd_addr_q <= '0;
         readdata  <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rd_v_q    <= read;
         rd_addr_q <= address;
         if (rd_v_q) begin
            readdata <= (rd_addr_q < LIMIT) ?
                        mem[rd_addr_q[AW-1:0]] : OOR_VALUE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we && !reset) mem[ram_wa] <= ram_wd;
   end

endmodule

// File: tb/tb_framebuffer_responder.sv
// Directed and randomized checks of the framebuffer responder
// against an array model of the pixel store.
module tb_framebuffer_responder;
   import fs_pkg::*;

   localparam int         DEPTH = 1000;
   localparam logic [7:0] OOR   = 8'hE5;

   logic        clk = 1'b0;
   logic        reset;
   logic [22:0] address;
   logic        read;
   logic [7:0]  readdata;
   logic        wr_valid;
   logic        wr_ready;
   logic [22:0] wr_address;
   logic [7:0]  wr_data;
   logic        clear;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] ref_mem [DEPTH];
   int         known_q [$];
   logic [7:0] last_exp;

   framebuffer_responder #(
      .DEPTH       (DEPTH),
      .FIFO_DEPTH  (4),
      .CLEAR_VALUE (8'h00),
      .OOR_VALUE   (OOR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .read       (read),
      .readdata   (readdata),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_address (wr_address),
      .wr_data    (wr_data),
      .clear      (clear),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_of(input logic [22:0] a);
      if (a >= DEPTH) return OOR;
      return ref_mem[a];
   endfunction

   task automatic do_write(input logic [22:0] a, input logic [7:0] d);
      int n = 0;
      wr_valid   = 1'b1;
      wr_address = a;
      wr_data    = d;
      while (!wr_ready && n < 50) begin
         tick;
         n++;
      end
      check("wr_handshake_bound", 32'(n < 50), 1);
      tick;
      wr_valid = 1'b0;
      if (a < DEPTH) begin
         ref_mem[a] = d;
         known_q.push_back(int'(a));
      end
   endtask

   task automatic rd_check(input string tag, input logic [22:0] a);
      read    = 1'b1;
      address = a;
      tick;
      read = 1'b0;
      tick;
      last_exp = exp_of(a);
      check(tag, readdata, last_exp);
   endtask

   task automatic settle;
      repeat (6) tick;
   endtask

   task automatic busy_run(input string tag, input int exp_len);
      int  n   = 0;
      bit  bad = 0;
      while (busy && n < DEPTH + 100) begin
         if (wr_ready) bad = 1;
         n++;
         tick;
      end
      check({tag, "_len"}, n, exp_len);
      check({tag, "_wr_ready_low"}, bad, 0);
      check({tag, "_busy_fall"}, busy, 0);
   endtask

   initial begin
      logic [7:0] hold;
      logic [7:0] pe;
      logic [7:0] en;
      logic [22:0] a;
      bit pv;
      bit rd;
      int acc;
      int n;

      reset      = 1'b1;
      address    = '0;
      read       = 1'b0;
      wr_valid   = 1'b0;
      wr_address = '0;
      wr_data    = '0;
      clear      = 1'b0;
      tick;
      tick;
      check("rst_readdata", readdata, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_ready_in_reset", wr_ready, 0);
      reset = 1'b0;
      #1;
      check("rst_wr_ready_after", wr_ready, 1);

      // write then read with exact latency
      do_write(23'd100, 8'h5A);
      settle;
      read    = 1'b1;
      address = 23'd100;
      tick;
      read = 1'b0;
      check("wr_rd_no_early", readdata, 8'h00);
      tick;
      check("wr_rd_data", readdata, 8'h5A);
      last_exp = 8'h5A;

      // back-to-back reads
      do_write(23'd0, 8'd1);
      do_write(23'd1, 8'd2);
      do_write(23'd2, 8'd3);
      settle;
      read = 1'b1;
      for (int i = 0; i < 3; i++) begin
         address = 23'(i);
         tick;
         if (i == 0) check("b2b_hold", readdata, last_exp);
         else check("b2b_data", readdata, exp_of(23'(i - 1)));
      end
      read = 1'b0;
      tick;
      check("b2b_last", readdata, 8'd3);

      // read priority and write backpressure
      read    = 1'b1;
      address = 23'd0;
      tick;
      wr_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         wr_address = 23'(200 + i);
         wr_data    = 8'($urandom);
         if (wr_ready) begin
            acc++;
            ref_mem[200 + i] = wr_data;
            known_q.push_back(200 + i);
         end
         tick;
      end
      wr_valid = 1'b0;
      check("bp_accepted", acc, 4);
      check("bp_ready_low", wr_ready, 0);
      read = 1'b0;
      n = 0;
      while (!wr_ready && n < 10) begin
         tick;
         n++;
      end
      check("bp_ready_back", wr_ready, 1);
      check("bp_drain_bound", 32'(n <= 4), 1);
      settle;
      for (int i = 0; i < 4; i++) rd_check("bp_data", 23'(200 + i));

      // out of range
      rd_check("oor_pre", 23'd100);
      rd_check("oor_depth", 23'(DEPTH));
      rd_check("oor_max", 23'h7FFFFF);
      do_write(23'd1024, 8'hFF);
      do_write(23'(DEPTH), 8'hFF);
      settle;
      rd_check("oor_wr_dropped", 23'd0);

      // randomized writes then random read stream
      for (int i = 0; i < 30; i++) begin
         do_write(23'($urandom_range(0, DEPTH + 50)), 8'($urandom));
      end
      settle;
      rd_check("rnd_seed", 23'd100);
      hold = last_exp;
      pv   = 0;
      pe   = '0;
      for (int c = 0; c < 60; c++) begin
         rd = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 7) == 0) a = 23'(DEPTH + $urandom_range(0, 5000));
         else a = 23'(known_q[$urandom_range(0, known_q.size() - 1)]);
         en      = exp_of(a);
         read    = rd;
         address = a;
         tick;
         if (pv) hold = pe;
         check("rnd_rd", readdata, hold);
         pv = rd;
         pe = en;
      end
      read = 1'b0;
      tick;
      if (pv) hold = pe;
      check("rnd_rd_tail", readdata, hold);

      // full clear
      for (int i = 0; i < 8; i++) do_write(23'(i), 8'hAA);
      settle;
      clear = 1'b1;
      tick;
      clear = 1'b0;
      busy_run("clr1", DEPTH + 1);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
      for (int i = 0; i < 8; i++) rd_check("clr1_data", 23'(i));
      rd_check("clr1_top", 23'(DEPTH - 1));
      rd_check("clr1_mid", 23'd100);

      // reset mid-sweep, with a write accepted alongside the clear
      do_write(23'd10, 8'h11);
      do_write(23'd900, 8'h3C);
      settle;
      clear      = 1'b1;
      wr_valid   = 1'b1;
      wr_address = 23'd20;
      wr_data    = 8'h99;
      check("clr_wr_same_cycle_ready", wr_ready, 1);
      tick;
      clear    = 1'b0;
      wr_valid = 1'b0;
      repeat (502) tick;
      check("mid_busy", busy, 1);
      read    = 1'b1;
      address = 23'd900;
      tick;
      read  = 1'b0;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_wr_ready", wr_ready, 1);
      check("mid_rst_readdata", readdata, 0);
      tick;
      check("mid_rst_read_dropped", readdata, 0);
      ref_mem[10] = 8'h00;
      ref_mem[20] = 8'h00;
      rd_check("mid_swept_10", 23'd10);
      rd_check("mid_swept_20", 23'd20);
      rd_check("mid_kept_900", 23'd900);

      clear = 1'b1;
      tick;
      clear = 1'b0;
      busy_run("clr2", DEPTH + 1);
      ref_mem[900] = 8'h00;
      rd_check("clr2_900", 23'd900);
      rd_check("clr2_top", 23'(DEPTH - 1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
